// File: rtl/apb_spi_if.sv
// APB bus bundle between an APB requester and the SPI master.
// Slave modport is the register-file side.
interface apb_spi_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output paddr,
    output psel,
    output penable,
    output pwrite,
    output pwdata,
    input  prdata,
    input  pready
  );

  modport slave (
    input  paddr,
    input  psel,
    input  penable,
    input  pwrite,
    input  pwdata,
    output prdata,
    output pready
  );
endinterface

// File: rtl/apb_spi_master.sv
// APB-programmed SPI mode-0 byte master.
// One byte per TXDATA write, MSB first, programmable sclk divider.
module apb_spi_master #(
  parameter logic [7:0] DIV_RST = 8'd1
) (
  input  logic     pclk,
  input  logic     preset,
  apb_spi_if.slave bus,
  output logic     sclk,
  output logic     mosi,
  output logic     ss_n,
  input  logic     miso,
  output logic     irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic       r_en;
  logic       r_ie;
  logic [7:0] r_div;
  logic [7:0] r_div_lat;
  logic [7:0] r_cnt;
  logic [3:0] r_half;
  logic       r_sclk;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rxdata;
  logic       r_rxv;
  logic       r_ovr;

  logic [2:0]  w_addr;
  logic        w_busy;
  logic        w_tx_wr;
  logic        w_pready;
  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic        w_a_ctrl;
  logic        w_a_tx;
  logic        w_a_rx;
  logic        w_a_stat;
  logic        w_a_div;
  logic        w_start;
  logic        w_half_end;
  logic        w_last;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_addr   = bus.paddr[4:2];
  assign w_a_ctrl = (w_addr == 3'd0);
  assign w_a_tx   = (w_addr == 3'd1);
  assign w_a_rx   = (w_addr == 3'd2);
  assign w_a_stat = (w_addr == 3'd3);
  assign w_a_div  = (w_addr == 3'd4);

  assign w_busy = (r_state != S_IDLE);

  // A new byte cannot be queued; stall the bus until the engine is idle.
  assign w_tx_wr  = bus.psel & bus.penable
                  & bus.pwrite & w_a_tx;
  assign w_pready = ~(w_tx_wr & r_en & w_busy);

  assign w_acc = bus.psel & bus.penable & w_pready;
  assign w_wr  = w_acc & bus.pwrite;
  assign w_rd  = w_acc & ~bus.pwrite;

  assign w_start = w_wr & w_a_tx & r_en
                 & (r_state == S_IDLE);

  assign w_half_end = (r_state == S_XFER)
                    & (r_cnt == r_div_lat);
  assign w_last     = w_half_end & (r_half == 4'd15);
  assign w_done     = (r_state == S_DONE);

  assign w_unused = ^{bus.paddr[31:5],
                      bus.paddr[1:0],
                      bus.pwdata[31:8]};

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = S_XFER;
        end
      end
      S_XFER: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Shift engine: half-period timer, sclk, shift in/out.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cnt     <= 8'd0;
      r_half    <= 4'd0;
      r_sclk    <= 1'b0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_div_lat <= 8'd0;
    end else if (w_start) begin
      r_tx      <= bus.pwdata[7:0];
      r_rx      <= 8'd0;
      r_div_lat <= r_div;
      r_cnt     <= 8'd0;
      r_half    <= 4'd0;
      r_sclk    <= 1'b0;
    end else if (r_state == S_XFER) begin
      if (w_half_end) begin
        r_cnt  <= 8'd0;
        r_half <= r_half + 4'd1;
        if (!r_half[0]) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], miso};
        end else begin
          r_sclk <= 1'b0;
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Register file; completion flags win over clears.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_en     <= 1'b0;
      r_ie     <= 1'b0;
      r_div    <= DIV_RST;
      r_rxdata <= 8'd0;
      r_rxv    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_wr && w_a_ctrl) begin
        r_ie <= bus.pwdata[1];
        r_en <= bus.pwdata[0];
      end
      if (w_wr && w_a_div && !w_busy) begin
        r_div <= bus.pwdata[7:0];
      end
      if (w_rd && w_a_rx) begin
        r_rxv <= 1'b0;
      end
      if (w_wr && w_a_stat && bus.pwdata[2]) begin
        r_ovr <= 1'b0;
      end
      if (w_done) begin
        r_rxdata <= r_rx;
        r_rxv    <= 1'b1;
        if (r_rxv) begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  // Read mux, zero when not a read.
  always_comb begin
    w_rdata = 32'h0;
    if (bus.psel && !bus.pwrite) begin
      unique case (1'b1)
        w_a_ctrl: w_rdata = {30'h0, r_ie, r_en};
        w_a_rx:   w_rdata = {24'h0, r_rxdata};
        w_a_stat: w_rdata = {29'h0, r_ovr,
                             r_rxv, w_busy};
        w_a_div:  w_rdata = {24'h0, r_div};
        default:  w_rdata = 32'h0;
      endcase
    end
  end

  assign bus.prdata = w_rdata;
  assign bus.pready = w_pready;

  assign sclk = r_sclk;
  assign mosi = (r_state == S_XFER) & r_tx[7];
  assign ss_n = (r_state == S_IDLE);
  assign irq  = r_ie & r_rxv;

endmodule

// File: tb/tb_apb_spi_master.sv
// Directed + randomized bench for apb_spi_master.
// Expected values come from a transaction-level model.
module tb_apb_spi_master;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic sclk;
  logic mosi;
  logic ss_n;
  logic miso;
  logic irq;
  int   miso_mode = 0;

  apb_spi_if bus();

  assign miso = (miso_mode == 1) ? 1'b1 : mosi;

  always #5 pclk = ~pclk;

  apb_spi_master #(.DIV_RST(8'd1)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus),
    .sclk   (sclk),
    .mosi   (mosi),
    .ss_n   (ss_n),
    .miso   (miso),
    .irq    (irq)
  );

  int checks = 0;
  int failures = 0;

  int cur_len = 0;
  int frame_len = 0;
  int frames = 0;
  int pulses = 0;
  int hw = 0;
  int hmin = 255;
  int hmax = 0;
  int high_run = 0;
  int gap_last = 0;
  int idle_viol = 0;
  logic prev_ss = 1'b1;
  logic prev_sclk = 1'b0;

  // Pin monitor: frame length, sclk pulse count/widths, gaps.
  initial begin
    forever begin
      @(negedge pclk);
      if (ss_n === 1'b0) begin
        if (prev_ss) begin
          gap_last = high_run;
          cur_len = 0;
          pulses = 0;
          hw = 0;
          hmin = 255;
          hmax = 0;
        end
        cur_len++;
        if (sclk === 1'b1) begin
          hw++;
          if (!prev_sclk) pulses++;
        end else if (prev_sclk) begin
          if (hw < hmin) hmin = hw;
          if (hw > hmax) hmax = hw;
          hw = 0;
        end
      end else begin
        if (!prev_ss) begin
          frame_len = cur_len;
          frames++;
          high_run = 0;
        end
        high_run++;
        if (sclk !== 1'b0) idle_viol++;
        if (mosi !== 1'b0) idle_viol++;
      end
      prev_ss = (ss_n !== 1'b0);
      prev_sclk = (sclk === 1'b1);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a,
                           input logic [31:0] d,
                           output int waits);
    logic rdy;
    @(negedge pclk);
    bus.paddr = a;
    bus.pwdata = d;
    bus.pwrite = 1'b1;
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    waits = 0;
    forever begin
      #1 rdy = bus.pready;
      @(posedge pclk);
      if (rdy) break;
      waits++;
      if (waits > 3000) begin
        checks++;
        failures++;
        $error("FAIL apb_write_timeout observed=%0d expected<3000",
               waits);
        break;
      end
      @(negedge pclk);
    end
    #1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a,
                          output logic [31:0] d);
    logic rdy;
    int n;
    @(negedge pclk);
    bus.paddr = a;
    bus.pwrite = 1'b0;
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    n = 0;
    forever begin
      #1 rdy = bus.pready;
      d = bus.prdata;
      @(posedge pclk);
      if (rdy) break;
      n++;
      if (n > 3000) begin
        checks++;
        failures++;
        $error("FAIL apb_read_timeout observed=%0d expected<3000",
               n);
        break;
      end
      @(negedge pclk);
    end
    #1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    int w;
    apb_write(a, d, w);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    apb_read(a, v);
    chk(tag, v, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (ss_n !== 1'b1 && n < 3000);
    if (ss_n !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL wait_idle_timeout observed=%0d expected<3000", n);
    end
    @(negedge pclk);
    #1;
  endtask

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_TX   = 32'h04;
  localparam logic [31:0] A_RX   = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_DIV  = 32'h10;

  // Transaction-level model state.
  logic       m_rxv;
  logic       m_ovr;
  logic [7:0] m_rxdata;
  logic [7:0] m_div;

  function automatic logic [31:0] m_stat();
    return {29'h0, m_ovr, m_rxv, 1'b0};
  endfunction

  // A completed byte lands in RXDATA; overrun if unread.
  task automatic m_complete(input logic [7:0] b);
    m_ovr = m_ovr | m_rxv;
    m_rxv = 1'b1;
    m_rxdata = b;
  endtask

  function automatic int frame_cycles(input logic [7:0] d);
    return 16 * (int'(d) + 1) + 1;
  endfunction

  initial begin
    int w0;
    int w1;
    int n;
    int fr;
    logic [7:0] tx;
    logic [7:0] dv;

    bus.paddr = 32'h0;
    bus.pwdata = 32'h0;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite = 1'b0;
    m_rxv = 1'b0;
    m_ovr = 1'b0;
    m_rxdata = 8'h00;
    m_div = 8'd1;

    // Reset state.
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    chk("rst_ss_n", {31'h0, ss_n}, 32'h1);
    chk("rst_sclk", {31'h0, sclk}, 32'h0);
    chk("rst_mosi", {31'h0, mosi}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_pready", {31'h0, bus.pready}, 32'h1);
    bus.paddr = A_DIV;
    #1;
    chk("prdata_nosel", bus.prdata, 32'h0);
    rd_chk("rst_status", A_STAT, 32'h0);
    rd_chk("rst_clkdiv", A_DIV, 32'h1);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_rxdata", A_RX, 32'h0);
    rd_chk("rd_txdata", A_TX, 32'h0);
    rd_chk("rd_unmapped14", 32'h14, 32'h0);
    rd_chk("rd_unmapped1c", 32'h1C, 32'h0);

    // Loopback 0xA5 at CLKDIV=1.
    wr(A_CTRL, 32'h1);
    wr(A_DIV, 32'h1);
    m_div = 8'd1;
    apb_write(A_TX, 32'hA5, w0);
    chk("a5_waits", w0, 32'd0);
    chk("a5_ss_low", {31'h0, ss_n}, 32'h0);
    chk("a5_mosi_msb", {31'h0, mosi}, 32'h1);
    wait_idle();
    m_complete(8'hA5);
    chk("a5_frame_len", frame_len, frame_cycles(m_div));
    chk("a5_pulses", pulses, 32'd8);
    chk("a5_hmin", hmin, int'(m_div) + 1);
    chk("a5_hmax", hmax, int'(m_div) + 1);
    rd_chk("a5_status", A_STAT, m_stat());
    chk("a5_irq_ie0", {31'h0, irq}, 32'h0);
    rd_chk("a5_rxdata", A_RX, {24'h0, m_rxdata});
    m_rxv = 1'b0;
    rd_chk("a5_status_clr", A_STAT, m_stat());

    // Back-to-back bytes; the second stalls until idle.
    apb_write(A_TX, 32'h3C, w0);
    apb_write(A_TX, 32'hC3, w1);
    chk("b2b_w0", w0, 32'd0);
    chk("b2b_w1", w1, 16 * (int'(m_div) + 1));
    wait_idle();
    m_complete(8'h3C);
    m_complete(8'hC3);
    chk("b2b_gap", gap_last, 32'd1);
    chk("b2b_frame_len", frame_len, frame_cycles(m_div));
    rd_chk("ovr_status", A_STAT, m_stat());
    wr(A_STAT, 32'h4);
    m_ovr = 1'b0;
    rd_chk("ovr_clr", A_STAT, m_stat());
    rd_chk("b2b_rxdata", A_RX, {24'h0, m_rxdata});
    m_rxv = 1'b0;
    rd_chk("ovr_final", A_STAT, m_stat());

    // EN cleared and CLKDIV written mid-transfer.
    wr(A_TX, 32'h5A);
    wr(A_CTRL, 32'h0);
    wr(A_DIV, 32'h5);
    rd_chk("busy_status", A_STAT, 32'h1);
    wait_idle();
    m_complete(8'h5A);
    chk("noabort_len", frame_len, frame_cycles(m_div));
    rd_chk("div_busy_ign", A_DIV, {24'h0, m_div});
    rd_chk("noabort_rx", A_RX, {24'h0, m_rxdata});
    m_rxv = 1'b0;
    fr = frames;
    wr(A_TX, 32'h77);
    repeat (5) @(negedge pclk);
    #1;
    chk("en0_no_frame", frames, fr);
    chk("en0_ss_n", {31'h0, ss_n}, 32'h1);
    rd_chk("en0_status", A_STAT, m_stat());

    // IRQ with CLKDIV=0 and miso held high.
    wr(A_CTRL, 32'h3);
    wr(A_DIV, 32'h0);
    m_div = 8'd0;
    miso_mode = 1;
    tx = 8'($urandom);
    wr(A_TX, {24'h0, tx});
    chk("irq_low_busy", {31'h0, irq}, 32'h0);
    wait_idle();
    m_complete(8'hFF);
    chk("irq_frame_len", frame_len, frame_cycles(m_div));
    chk("irq_hmax", hmax, 32'd1);
    chk("irq_pulses", pulses, 32'd8);
    chk("irq_high", {31'h0, irq}, 32'h1);
    rd_chk("irq_rxdata", A_RX, {24'h0, m_rxdata});
    m_rxv = 1'b0;
    chk("irq_fall", {31'h0, irq}, 32'h0);
    miso_mode = 0;

    // Randomized loopback bytes and dividers.
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      dv = 8'($urandom_range(0, 3));
      tx = 8'($urandom);
      wr(A_DIV, {24'h0, dv});
      m_div = dv;
      wr(A_TX, {24'h0, tx});
      wait_idle();
      m_complete(tx);
      chk("rnd_frame_len", frame_len, frame_cycles(m_div));
      chk("rnd_pulses", pulses, 32'd8);
      chk("rnd_hmin", hmin, int'(m_div) + 1);
      chk("rnd_hmax", hmax, int'(m_div) + 1);
      rd_chk("rnd_rxdata", A_RX, {24'h0, m_rxdata});
      m_rxv = 1'b0;
      rd_chk("rnd_status", A_STAT, m_stat());
    end

    // Reset in the middle of the 4th sclk pulse.
    wr(A_DIV, 32'h1);
    m_div = 8'd1;
    wr(A_TX, 32'hE7);
    n = 0;
    do begin
      @(negedge pclk);
      #1;
      n++;
    end while (pulses < 4 && n < 500);
    chk("mid_pulse4_seen", pulses, 32'd4);
    preset = 1'b1;
    @(posedge pclk);
    #1;
    m_rxv = 1'b0;
    m_ovr = 1'b0;
    m_rxdata = 8'h00;
    m_div = 8'd1;
    chk("mid_rst_ss_n", {31'h0, ss_n}, 32'h1);
    chk("mid_rst_sclk", {31'h0, sclk}, 32'h0);
    chk("mid_rst_mosi", {31'h0, mosi}, 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    rd_chk("mid_rst_status", A_STAT, m_stat());
    rd_chk("mid_rst_rxdata", A_RX, {24'h0, m_rxdata});
    rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
    rd_chk("mid_rst_div", A_DIV, {24'h0, m_div});
    chk("idle_pins_quiet", idle_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
